// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the multi-cycle 32-bit divider.
// Latches the operands on accept, holds them steady while the divider works,
// and produces exactly one HI/LO write per instruction that is not flushed.
// Once a division ends, it spends two drain cycles with start low so the divider
// reaches its free state before the next request is accepted.
//
//   state | meaning
//   IDLE  | no division in flight; accept a request when one arrives
//   BUSY  | divider running; wait for ready, flush or timeout
//   HOLD  | result delivered but EX is frozen; keep whilo and hi/lo steady
//   DRAIN | two cycles with start low while the divider returns to free
module div_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic        ex_adv_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic             signed_q, signed_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // Next-state and output decode; outputs are combinational from state and inputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    signed_d      = signed_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    div_start_o   = 1'b0;
    div_annul_o   = 1'b0;
    div_signed_o  = 1'b0;
    div_opdata1_o = 32'd0;
    div_opdata2_o = 32'd0;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    hi_o          = 32'd0;
    lo_o          = 32'd0;
    timeout_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_req_i && !flush_i) begin
          div_start_o   = 1'b1;
          div_signed_o  = div_signed_i;
          div_opdata1_o = reg1_i;
          div_opdata2_o = reg2_i;
          stallreq_o    = 1'b1;
          op1_d         = reg1_i;
          op2_d         = reg2_i;
          signed_d      = div_signed_i;
          cnt_d         = '0;
          state_d       = BUSY;
        end
      end

      BUSY: begin
        div_start_o   = 1'b1;
        div_signed_o  = signed_q;
        div_opdata1_o = op1_q;
        div_opdata2_o = op2_q;
        cnt_d         = cnt_q + 1'b1;
        if (flush_i) begin
          div_annul_o = 1'b1;
          div_start_o = 1'b0;
          drain_d     = 1'b0;
          state_d     = DRAIN;
        end else if (div_ready_i) begin
          whilo_o = 1'b1;
          hi_o    = div_result_i[63:32];
          lo_o    = div_result_i[31:0];
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          drain_d = 1'b0;
          state_d = ex_adv_i ? DRAIN : HOLD;
        end else if (cnt_q == CNT_LAST) begin
          // Divider never answered: abort it and write zeros so the instruction still retires.
          div_annul_o = 1'b1;
          timeout_o   = 1'b1;
          whilo_o     = 1'b1;
          drain_d     = 1'b0;
          state_d     = DRAIN;
        end else begin
          stallreq_o = 1'b1;
        end
      end

      HOLD: begin
        div_signed_o  = signed_q;
        div_opdata1_o = op1_q;
        div_opdata2_o = op2_q;
        whilo_o       = 1'b1;
        hi_o          = hi_q;
        lo_o          = lo_q;
        if (ex_adv_i || flush_i) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        stallreq_o = div_req_i;
        drain_d    = 1'b1;
        if (drain_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      div_start_o   = 1'b0;
      div_annul_o   = 1'b0;
      div_signed_o  = 1'b0;
      div_opdata1_o = 32'd0;
      div_opdata2_o = 32'd0;
      stallreq_o    = 1'b0;
      whilo_o       = 1'b0;
      hi_o          = 32'd0;
      lo_o          = 32'd0;
      timeout_o     = 1'b0;
    end
  end

  // State, counters and latched operand/result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      signed_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
